// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared constants for the MEM->WB boundary: regfile geometry and payload sizing.
package pipe_defs;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDR_WIDTH    = 5;
    localparam int ZERO_REG_ADDR = 0;

    // Packed payload = {data, addr, we[, hi, lo, whilo]}
    function automatic int payload_w(input int dw, input int aw, input int hilo_en);
        return dw + aw + 1 + hilo_en * (2 * dw + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with flush; in_ready is purely registered.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid, skid_valid;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             acc, drn;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign acc       = in_valid & in_ready;
    assign drn       = main_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // Payloads may go stale; only the valids matter downstream.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drn) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= acc;
                if (acc) skid_data <= in_data;
            end else if (acc) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (acc) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: skid-buffered handshake, qualified write enables, stall counter.
module mem_wb_pipe_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int HILO_EN    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_reg_write_data,
    input  logic [ADDR_WIDTH-1:0] mem_reg_write_addr,
    input  logic                  mem_reg_write_en,
    input  logic [DATA_WIDTH-1:0] mem_hi,
    input  logic [DATA_WIDTH-1:0] mem_lo,
    input  logic                  mem_whilo,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_reg_write_data,
    output logic [ADDR_WIDTH-1:0] wb_reg_write_addr,
    output logic                  wb_reg_write_en,
    output logic [DATA_WIDTH-1:0] wb_hi,
    output logic [DATA_WIDTH-1:0] wb_lo,
    output logic                  wb_whilo,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    import pipe_defs::*;

    localparam int PW = payload_w(DATA_WIDTH, ADDR_WIDTH, (HILO_EN != 0) ? 1 : 0);

    logic [PW-1:0]         in_payload, out_payload;
    logic                  main_valid, main_we, main_whilo;
    logic [ADDR_WIDTH-1:0] main_addr;

    generate
        if (HILO_EN != 0) begin : g_hilo
            assign in_payload = {mem_reg_write_data, mem_reg_write_addr, mem_reg_write_en,
                                 mem_hi, mem_lo, mem_whilo};
            assign {wb_reg_write_data, main_addr, main_we, wb_hi, wb_lo, main_whilo} = out_payload;
        end else begin : g_no_hilo
            logic unused_hilo;
            assign unused_hilo = ^{mem_hi, mem_lo, mem_whilo};
            assign in_payload  = {mem_reg_write_data, mem_reg_write_addr, mem_reg_write_en};
            assign {wb_reg_write_data, main_addr, main_we} = out_payload;
            assign wb_hi      = '0;
            assign wb_lo      = '0;
            assign main_whilo = 1'b0;
        end
    endgenerate

    pipe_skid_buf #(.WIDTH(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (mem_valid),
        .in_ready  (mem_ready),
        .in_data   (in_payload),
        .out_valid (main_valid),
        .out_ready (wb_ready),
        .out_data  (out_payload)
    );

    assign wb_valid          = main_valid;
    assign wb_reg_write_addr = main_addr;
    // $zero writes never reach the regfile.
    assign wb_reg_write_en   = main_valid & main_we & (main_addr != ADDR_WIDTH'(ZERO_REG_ADDR));
    assign wb_whilo          = main_valid & main_whilo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (wb_valid && !wb_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM→WB pipeline register: the next-generation write-back stage boundary.
- Carries the GPR write channel, plus an optional HI/LO write channel.
- Adds a valid/ready handshake with a one-entry skid buffer, so WB back-pressure never drops MEM results, and a flush input.
- Adds a saturating back-pressure stall counter for performance monitoring.
- Sits between the MEM stage and the regfile/HI-LO write ports.

Parameters:
- DATA_WIDTH, 32, width of GPR and HI/LO data.
- ADDR_WIDTH, 5, GPR address width.
- HILO_EN, 1, 1 = HI/LO channel present; 0 = HI/LO outputs tied to 0 and inputs ignored.
- CNT_WIDTH, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all held and incoming entries.
- mem_valid  in  1  MEM presents a result.
- mem_ready  out  1  stage can accept.
- mem_reg_write_data  in  DATA_WIDTH  GPR write data.
- mem_reg_write_addr  in  ADDR_WIDTH  GPR write address.
- mem_reg_write_en  in  1  GPR write request.
- mem_hi  in  DATA_WIDTH  HI data.
- mem_lo  in  DATA_WIDTH  LO data.
- mem_whilo  in  1  HI/LO write request.
- wb_valid  out  1  output entry valid.
- wb_ready  in  1  WB consumes entry.
- wb_reg_write_data  out  DATA_WIDTH
- wb_reg_write_addr  out  ADDR_WIDTH
- wb_reg_write_en  out  1  qualified GPR write enable.
- wb_hi  out  DATA_WIDTH
- wb_lo  out  DATA_WIDTH
- wb_whilo  out  1  qualified HI/LO write enable.
- stall_cnt  out  CNT_WIDTH  cycles with wb_valid=1 and wb_ready=0, saturating.

Behaviour:
- Reset (async, immediate on rst rise): all registers zero. This covers main and skid payloads and valids, all wb_* outputs, and stall_cnt.
- Storage: main entry (drives wb_*) and skid entry. Payload = {data, addr, we, hi, lo, whilo}.
- mem_ready = ~skid_valid (registered source only; no combinational path from wb_ready).
- Accept: acc = mem_valid & mem_ready. Drain: drn = wb_valid & wb_ready.
- Latency: an accepted entry appears on wb_* the next cycle when main is empty or draining.
- Per-edge update, no flush, priority order:
  - main empty or drn, skid valid → main ← skid, skid empties. If acc also happens in this case, the input goes to skid (cannot happen while skid is valid, since mem_ready=0).
  - main empty or drn, skid empty → main ← input if acc, else main_valid ← 0.
  - main valid, not drn, acc → skid ← input; mem_ready falls next cycle.
  - otherwise hold.
- Ordering: strict FIFO, maximum 2 entries; no entry is duplicated or lost.
- flush=1 at an edge:
  - main_valid and skid_valid ← 0, and any acc in that cycle is discarded.
  - Payload registers may hold stale data; the enables are qualified (see below).
  - flush has priority over all other updates; stall_cnt is unaffected.
- Qualified enables (combinational from regs):
  - wb_reg_write_en = main_valid & main_we & (main_addr != 0). Writes to $zero are suppressed.
  - wb_whilo = HILO_EN & main_valid & main_whilo.
  - wb_valid = main_valid.
- Data outputs are registered main payload.
- HILO_EN=0: hi/lo/whilo storage absent; wb_hi = wb_lo = 0.
- stall_cnt: +1 each edge with wb_valid & ~wb_ready; holds at all-ones; cleared only by rst.
- Reset mid-operation: both entries are lost and stall_cnt is zeroed; mem_ready = 1 immediately after reset deasserts.
- mem_ready depends only on state, so MEM may hold mem_valid while mem_ready=0; inputs are sampled only on acc.

Decomposition:
- Shared package/header `pipe_defs`:
  - constants DATA_WIDTH=32 and ADDR_WIDTH=5 (matching regfile defines), ZERO_REG_ADDR=0.
  - payload field offsets/width function PAYLOAD_W = DATA_WIDTH+ADDR_WIDTH+1+HILO_EN*(2*DATA_WIDTH+1).
- One natural sub-module: pipe_skid_buf (generic WIDTH-parameter 2-entry valid/ready skid buffer with flush). mem_wb_pipe_reg packs/unpacks the payload, qualifies the enables and owns stall_cnt.

Test Plan:
- Reset then stream:
  - Stimulus: wb_ready=1; send data=0x1234_5678, addr=3, we=1 on cycles 1..4 with data +1 each.
  - Required: wb_* shows each one cycle later in order; mem_ready stays 1; stall_cnt=0.
- Back-pressure:
  - Stimulus: hold wb_ready=0 and send A=0xA, then B=0xB.
  - Required: wb holds A; mem_ready=0 after B is accepted; C (0xC) offered while mem_ready=0 is not accepted.
  - Then: release wb_ready → output A, B, C; stall_cnt equals the number of stalled cycles.
- Flush:
  - Stimulus: with main=A and skid=B held, assert flush for one cycle together with mem_valid (D).
  - Required: next cycle wb_valid=0, wb_reg_write_en=0, mem_ready=1; D never appears.
- $zero suppression:
  - Stimulus: addr=0, we=1, data=0xDEAD_BEEF.
  - Required: wb_valid=1, wb_reg_write_en=0.
  - Then: addr=31 → wb_reg_write_en=1.
- HI/LO channel:
  - Stimulus: hi=0x1, lo=0x2, whilo=1.
  - Required: wb_hi=0x1, wb_lo=0x2, wb_whilo=1.
  - HILO_EN=0 build: wb_whilo=0 and hi/lo=0.
- Async reset mid-stall, with CNT_WIDTH=4:
  - Stimulus: stall 20 cycles.
  - Required: stall_cnt saturates at 15.
  - Then: pulse rst between edges → all outputs 0 immediately, before the next clk edge.
